alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Consumer end of the 3-bit ALUControl interface driven by the ALU decoder in the RISC-V core.
//  Executes the selected operation on two operands and returns Result plus Zero/Negative/Carry/Overflow flags.
//  Uses a valid/ready handshake on both the operand side and the result side.
//  Adds iterative shifts (SLL/SRL) on the codes the decoder leaves unused; it is the execution stage for the multi-cycle core.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  SHW    5   shift-amount width; equals log2(WIDTH)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous, active-low reset
//  in_valid    in   1      operands and ALUControl valid
//  in_ready    out  1      unit can accept a new operation
//  ALUControl  in   3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL
//  SrcA        in   WIDTH  operand A
//  SrcB        in   WIDTH  operand B; SrcB[SHW-1:0] is the shift amount for SLL/SRL
//  out_valid   out  1      Result and flags are valid
//  out_ready   in   1      downstream accepts the result
//  Result      out  WIDTH  registered result
//  Zero        out  1      Result == 0
//  Negative    out  1      Result[WIDTH-1]
//  Carry       out  1      ADD: carry-out; SUB: carry-out of A+~B+1 (1 = no borrow); all other ops 0
//  Overflow    out  1      signed overflow for ADD/SUB; all other ops 0
//  busy        out  1      state is SHIFT
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): state=IDLE; Result, flags, out_valid and busy all 0; in_ready=0 while rst=0.
//  - Reset mid-SHIFT or in DONE: the in-flight operation is discarded and no result is delivered.
//  - States:
//      IDLE  : in_ready=1; waits for an accept.
//      SHIFT : iterative shift; in_ready=0, busy=1.
//      DONE  : out_valid=1.
//  - Accept = in_valid & in_ready. ALUControl, SrcA and SrcB are sampled only at accept; later changes are ignored.
//  - in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready and gives back-to-back throughput of 1 op per cycle for single-cycle ops.
//  - Single-cycle ops (000-101):
//      Result and flags are registered at accept; next state is DONE.
//      Latency: 1 cycle, accept to out_valid.
//  - SLT: Result = {0.., (A-B)[WIDTH-1] ^ ovf(A-B)} (signed compare); Carry=0, Overflow=0.
//  - ADD/SUB arithmetic:
//      Computed WIDTH+1 bits wide; Result wraps modulo 2^WIDTH.
//      Overflow = (A[msb]==B'[msb]) & (R[msb]!=A[msb]), where B'=B for ADD and B'=~B for SUB.
//  - SLL/SRL:
//      At accept: load the shift register with SrcA and the counter with SrcB[SHW-1:0].
//      If count==0: go straight to DONE with Result=SrcA (latency 1).
//      Otherwise go to SHIFT. Each SHIFT cycle shifts by one bit (zero fill) and decrements the counter.
//      When the counter reaches 1, the final shift is written to Result and the state moves to DONE.
//      Latency = max(1, shamt) cycles; SrcB bits above SHW are ignored.
//  - DONE: Result and flags are held stable until out_ready=1.
//      out_ready=1 with no new accept: next state is IDLE.
//      out_ready=1 with a simultaneous accept: the new op proceeds as if accepted from IDLE.
//  - Zero and Negative are always derived from the Result value being registered.
// STRUCTURE
//  - Package alu_pkg holds:
//      localparams ALU_ADD..ALU_SRL (the 3-bit codes above);
//      state encoding ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
//      the default WIDTH.
//  - Sub-module alu_comb_core is purely combinational: codes 000-101 -> result and flags.
//  - The top level holds the FSM, the operand/shift registers, the counter and the output registers.
// TESTING
//  - ADD 0x7FFFFFFF + 0x00000001 -> Result 0x80000000, Overflow=1, Negative=1, Carry=0, Zero=0; out_valid one cycle after accept.
//  - SUB 5 - 5 -> Result 0, Zero=1, Carry=1. SUB 3 - 5 -> Result 0xFFFFFFFE, Carry=0, Negative=1.
//  - SLT 0xFFFFFFFF vs 0x00000001 -> Result 1. SLT 1 vs 0xFFFFFFFF -> Result 0.
//  - SLL 0x00000001 by 31 -> busy for 30 cycles, out_valid 31 cycles after accept, Result 0x80000000. SRL by 0 -> 1 cycle, Result=SrcA.
//  - Backpressure: hold out_ready=0 for 5 cycles in DONE -> Result stable and in_ready=0. Then out_ready=1 with in_valid=1 (AND) -> new result appears the next cycle.
//  - Assert rst=0 midway through a 20-cycle SLL -> outputs are 0 immediately and out_valid never rises for that op.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, FSM state encoding and default datapath width.
package alu_pkg;
    localparam int DEF_WIDTH = 32;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/alu_if.sv
// alu_if: operand/result valid-ready bundle between the ALU decoder side and the execution unit.
interface alu_if import alu_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Negative;
    logic             Carry;
    logic             Overflow;
    logic             busy;
    modport master (
        output in_valid, ALUControl, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, Result, Zero, Negative, Carry, Overflow, busy
    );
    modport slave (
        input  in_valid, ALUControl, SrcA, SrcB, out_ready,
        output in_ready, out_valid, Result, Zero, Negative, Carry, Overflow, busy
    );
endinterface

// File: rtl/alu_comb_core.sv
// alu_comb_core: single-cycle ALU ops (ADD..SLT) with carry and signed-overflow flags.
module alu_comb_core import alu_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             ovf
);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   sum;
    logic             arith;
    logic             sv;
    // SUB and SLT share the A + ~B + 1 adder path
    always_comb begin
        arith = (op == ALU_ADD) || (op == ALU_SUB);
        bb    = (op == ALU_ADD) ? b : ~b;
        sum   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, op != ALU_ADD};
        sv    = (a[WIDTH-1] == bb[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
        y     = (op == ALU_AND) ? a & b :
                (op == ALU_OR)  ? a | b :
                (op == ALU_XOR) ? a ^ b :
                (op == ALU_SLT) ? {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sv} :
                arith           ? sum[WIDTH-1:0] : '0;
        carry = arith & sum[WIDTH];
        ovf   = arith & sv;
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU execution stage with iterative SLL/SRL and registered result/flags.
module alu_exec_unit import alu_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic   clk,
    input logic   rst,
    alu_if.slave  bus
);
    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_nx;
    logic [WIDTH-1:0] a_sh1;
    logic [WIDTH-1:0] core_y;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] result;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   amt;
    logic             dir;
    logic             accept;
    logic             shift_op;
    logic             multi;
    logic             last;
    logic             ld;
    logic             core_c;
    logic             core_v;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .op    (bus.ALUControl),
        .a     (bus.SrcA),
        .b     (bus.SrcB),
        .y     (core_y),
        .carry (core_c),
        .ovf   (core_v)
    );

    // The first shift happens at accept, so a shift by N spends N-1 cycles in SHIFT
    assign amt      = bus.SrcB[SHW-1:0];
    assign shift_op = bus.ALUControl[2] & bus.ALUControl[1];
    assign multi    = shift_op & (|amt[SHW-1:1]);
    assign accept   = bus.in_valid & bus.in_ready;
    assign a_sh1    = bus.ALUControl[0] ? bus.SrcA >> 1 : bus.SrcA << 1;
    assign sh_nx    = dir ? sh >> 1 : sh << 1;
    assign last     = (state == ST_SHIFT) && (cnt == SHW'(1));
    assign ld       = (accept & ~multi) | last;
    assign res_d    = (state == ST_SHIFT) ? sh_nx :
                      shift_op ? ((amt == '0) ? bus.SrcA : a_sh1) : core_y;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= ST_IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = accept ? (multi ? ST_SHIFT : ST_DONE) :
                   (state == ST_SHIFT) ? (last ? ST_DONE : ST_SHIFT) :
                   (state == ST_DONE && bus.out_ready) ? ST_IDLE : state;
    end

    always_comb begin
        bus.in_ready  = rst & ((state == ST_IDLE) | ((state == ST_DONE) & bus.out_ready));
        bus.out_valid = state == ST_DONE;
        bus.busy      = state == ST_SHIFT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh     <= '0;
            cnt    <= '0;
            dir    <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (ld) begin
                result <= res_d;
                zero   <= ~|res_d;
                neg    <= res_d[WIDTH-1];
                carry  <= (state != ST_SHIFT) & core_c;
                ovf    <= (state != ST_SHIFT) & core_v;
            end
            if (accept) begin
                sh  <= a_sh1;
                cnt <= amt - SHW'(1);
                dir <= bus.ALUControl[0];
            end else if (state == ST_SHIFT) begin
                sh  <= sh_nx;
                cnt <= cnt - SHW'(1);
            end
        end
    end

    assign bus.Result   = result;
    assign bus.Zero     = zero;
    assign bus.Negative = neg;
    assign bus.Carry    = carry;
    assign bus.Overflow = ovf;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and random checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;

    alu_if #(.WIDTH(32)) bus ();
    alu_exec_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c, output logic v);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic [32:0] wide;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op)
            3'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[31:0];
                c = wide[32];
                v = (sa + sb > 64'sd2147483647) || (sa + sb < -64'sd2147483648);
            end
            3'd1: begin
                r = a - b;
                c = a >= b;
                v = (sa - sb > 64'sd2147483647) || (sa - sb < -64'sd2147483648);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: r = a << b[4:0];
            default: r = a >> b[4:0];
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic c, v;
        int lat, busy_n, exp_lat;
        model(op, a, b, r, c, v);
        exp_lat = (op >= 3'd6 && b[4:0] > 5'd1) ? int'(b[4:0]) : 1;
        @(negedge clk);
        bus.ALUControl = op;
        bus.SrcA = a;
        bus.SrcB = b;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.ALUControl = 3'($urandom);
        bus.SrcA = $urandom;
        bus.SrcB = $urandom;
        lat = 1;
        busy_n = 0;
        while (!bus.out_valid && lat < 100) begin
            busy_n += int'(bus.busy);
            @(negedge clk);
            lat++;
        end
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
        chk({tag, ".Result"}, 64'(bus.Result), 64'(r));
        chk({tag, ".flags"}, 64'({bus.Zero, bus.Negative, bus.Carry, bus.Overflow}),
            64'({r == 32'd0, r[31], c, v}));
    endtask

    initial begin
        logic [31:0] r, pr, ra, rb;
        logic c, v, pc, pv;
        logic [2:0] op;
        int seen;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.ALUControl = 3'd0;
        bus.SrcA = '0;
        bus.SrcB = '0;
        #12;
        chk("reset.outputs", 64'({bus.in_ready, bus.out_valid, bus.busy, bus.Zero, bus.Negative, bus.Carry, bus.Overflow}), 64'd0);
        chk("reset.Result", 64'(bus.Result), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        run_op("sub_eq", 3'd1, 32'd5, 32'd5);
        run_op("sub_neg", 3'd1, 32'd3, 32'd5);
        run_op("slt_neg", 3'd5, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("slt_pos", 3'd5, 32'h0000_0001, 32'hFFFF_FFFF);
        run_op("sll31", 3'd6, 32'h0000_0001, 32'd31);
        run_op("srl0", 3'd7, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
        run_op("srl1", 3'd7, 32'h8000_0000, 32'd1);
        run_op("sll2", 3'd6, 32'h0000_0003, 32'd2);

        // Backpressure: result held while out_ready=0, then release with a simultaneous accept
        @(negedge clk);
        model(3'd0, 32'h1234_5678, 32'h1111_1111, r, c, v);
        bus.ALUControl = 3'd0;
        bus.SrcA = 32'h1234_5678;
        bus.SrcB = 32'h1111_1111;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.ALUControl = 3'd4;
        bus.SrcA = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            chk("bp.out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp.in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp.Result", 64'(bus.Result), 64'(r));
            @(negedge clk);
        end
        bus.ALUControl = 3'd2;
        bus.SrcA = 32'hF0F0_00FF;
        bus.SrcB = 32'h0FF0_0F0F;
        bus.out_ready = 1'b1;
        #1;
        chk("bp.release_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp.and_valid", 64'(bus.out_valid), 64'd1);
        chk("bp.and_Result", 64'(bus.Result), 64'h00F0_000F);
        @(negedge clk);
        chk("bp.idle_valid", 64'(bus.out_valid), 64'd0);

        // Back-to-back single-cycle ops, one per cycle
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                chk("b2b.out_valid", 64'(bus.out_valid), 64'd1);
                chk("b2b.in_ready", 64'(bus.in_ready), 64'd1);
                chk("b2b.Result", 64'(bus.Result), 64'(pr));
                chk("b2b.flags", 64'({bus.Zero, bus.Negative, bus.Carry, bus.Overflow}),
                    64'({pr == 32'd0, pr[31], pc, pv}));
            end
            op = 3'($urandom_range(5));
            ra = $urandom;
            rb = (i == 3) ? ra : $urandom;
            model(op, ra, rb, pr, pc, pv);
            bus.ALUControl = op;
            bus.SrcA = ra;
            bus.SrcB = rb;
            bus.in_valid = 1'b1;
            bus.out_ready = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("b2b.last_Result", 64'(bus.Result), 64'(pr));

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            run_op("rand", 3'($urandom_range(7)), ra, rb);
        end

        // Reset in the middle of a 20-cycle shift discards it
        @(negedge clk);
        bus.ALUControl = 3'd6;
        bus.SrcA = 32'h0000_0005;
        bus.SrcB = 32'd20;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_mid.busy_before", 64'(bus.busy), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid.outputs", 64'({bus.in_ready, bus.out_valid, bus.busy, bus.Zero, bus.Negative, bus.Carry, bus.Overflow}), 64'd0);
        chk("rst_mid.Result", 64'(bus.Result), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            seen += int'(bus.out_valid);
        end
        chk("rst_mid.no_result", 64'(seen), 64'd0);
        run_op("post_rst_add", 3'd0, 32'hFFFF_FFFF, 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
